ram_banked: RTL and testbench

Parametrised, banked successor to the fixed 512-word RAM in the sequential-logic tier: a 2^ADDR_BITS × WIDTH word memory split into 2^BANK_BITS equal banks selected by the address MSBs. It keeps the Hack-style interface (`out = M[address]`, write on `load`) and adds a built-in zero-fill engine, run after reset or on request, that reports progress on `busy`. It replaces hand-instantiated RAM512/RAM4K/RAM16K trees in the computer top level.

---
 rtl/ram_banked.sv | 113 +++++++++++
 tb/tb_ram_banked.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_banked.sv
// ram_banked: 2^ADDR_BITS x WIDTH word memory split into 2^BANK_BITS banks on the
// address MSBs, with asynchronous read and a zero-fill sweep after reset or on clear.
module ram_banked #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 9,
  parameter int BANK_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  localparam int ROW_BITS   = ADDR_BITS - BANK_BITS;
  localparam int BANKS      = 1 << BANK_BITS;
  localparam int BANK_DEPTH = 1 << ROW_BITS;
  localparam int SEL_BITS   = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam logic [ROW_BITS-1:0] ROW_LAST = {ROW_BITS{1'b1}};
  localparam logic [ROW_BITS-1:0] ROW_ZERO = {ROW_BITS{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                     state_r;
  state_t                     state_nx_s;
  logic [ROW_BITS-1:0]        ptr_r;
  logic [ROW_BITS-1:0]        ptr_nx_s;
  logic [SEL_BITS-1:0]        bank_s;
  logic [ROW_BITS-1:0]        row_s;
  logic                       sweep_en_s;
  logic                       wr_en_s;
  logic [BANKS-1:0][WIDTH-1:0] rd_data_s;
  logic [WIDTH-1:0]           rd_sel_s;

  assign row_s = address[ROW_BITS-1:0];

  // A single-bank build has no select field, so bank 0 is hard-wired.
  if (BANK_BITS > 0) begin : g_sel
    assign bank_s   = address[ADDR_BITS-1 -: SEL_BITS];
    assign rd_sel_s = rd_data_s[bank_s];
  end else begin : g_nosel
    assign bank_s   = {SEL_BITS{1'b0}};
    assign rd_sel_s = rd_data_s[0];
  end

  assign sweep_en_s = (state_r == ST_CLEAR);
  assign wr_en_s    = (state_r == ST_IDLE) && load && !clear && !reset;

  // State and sweep-pointer register; reset restarts the sweep from row 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      ptr_r   <= ROW_ZERO;
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
    end
  end

  // Next-state logic: clear requests are only honoured while idle.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          state_nx_s = ST_CLEAR;
          ptr_nx_s   = ROW_ZERO;
        end else begin
          state_nx_s = ST_IDLE;
          ptr_nx_s   = ptr_r;
        end
      end
      ST_CLEAR: begin
        ptr_nx_s = ptr_r + ROW_BITS'(1);
        if (ptr_r == ROW_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_CLEAR;
        end
      end
      default: begin
        state_nx_s = ST_CLEAR;
        ptr_nx_s   = ROW_ZERO;
      end
    endcase
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem_r [BANK_DEPTH];

    // Bank storage: the sweep zeroes the same row in every bank at once.
    always_ff @(posedge clk) begin
      if (sweep_en_s) begin
        mem_r[ptr_r] <= {WIDTH{1'b0}};
      end else if (wr_en_s && (bank_s == SEL_BITS'(b))) begin
        mem_r[row_s] <= in;
      end
    end

    assign rd_data_s[b] = mem_r[row_s];
  end

  assign busy = sweep_en_s;
  assign out  = sweep_en_s ? {WIDTH{1'b0}} : rd_sel_s;

endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked: default build against an array reference model,
// plus a four-bank build and a tiny single-bank build.
module tb_ram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, load = 1'b0, clear = 1'b0;
  logic [8:0]  address = 9'd0;
  logic [15:0] din = 16'd0, out;
  logic        busy;

  logic        q_reset = 1'b0, q_load = 1'b0, q_clear = 1'b0;
  logic [8:0]  q_address = 9'd0;
  logic [15:0] q_in = 16'd0, q_out;
  logic        q_busy;

  logic        c_reset = 1'b0, c_load = 1'b0, c_clear = 1'b0;
  logic [3:0]  c_address = 4'd0;
  logic [7:0]  c_in = 8'd0, c_out;
  logic        c_busy;

  ram_banked #(.WIDTH(16), .ADDR_BITS(9), .BANK_BITS(1)) dut (
    .clk(clk), .reset(reset), .address(address), .in(din), .load(load),
    .clear(clear), .out(out), .busy(busy));

  ram_banked #(.WIDTH(16), .ADDR_BITS(9), .BANK_BITS(2)) dut_q (
    .clk(clk), .reset(q_reset), .address(q_address), .in(q_in), .load(q_load),
    .clear(q_clear), .out(q_out), .busy(q_busy));

  ram_banked #(.WIDTH(8), .ADDR_BITS(4), .BANK_BITS(0)) dut_c (
    .clk(clk), .reset(c_reset), .address(c_address), .in(c_in), .load(c_load),
    .clear(c_clear), .out(c_out), .busy(c_busy));

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: word array plus number of sweep cycles still to run.
  logic [15:0] m_mem [512];
  int          m_left = 0;
  int          busy_cnt = 0;
  logic        last_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 512; i++) m_mem[i] = 16'h0000;
  endtask

  // One clock of the default DUT: drive at negedge, check, then advance the model.
  task automatic cyc(input string tag, input logic r, input logic c, input logic l,
                     input logic [8:0] a, input logic [15:0] d, input bit chk);
    @(negedge clk);
    reset = r; clear = c; load = l; address = a; din = d;
    #1;
    last_busy = busy;
    if (busy === 1'b1) busy_cnt++;
    if (chk) begin
      check({tag, "/busy"}, 32'(busy), (m_left > 0) ? 32'd1 : 32'd0);
      check({tag, "/out"}, 32'(out), (m_left > 0) ? 32'd0 : 32'(m_mem[a]));
    end
    if (r) begin
      m_left = 256; model_zero();
    end else if (m_left > 0) begin
      m_left--;
    end else if (c) begin
      m_left = 256; model_zero();
    end else if (l) begin
      m_mem[a] = d;
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 1'b0, 9'($urandom), 16'($urandom), 1'b1);
  endtask

  task automatic rd(input string tag, input logic [8:0] a);
    cyc(tag, 1'b0, 1'b0, 1'b0, a, 16'($urandom), 1'b1);
  endtask

  task automatic run_idle(input string tag);
    for (int i = 0; i < 1000; i++) begin
      idle(tag);
      if (!last_busy) break;
    end
  endtask

  initial begin
    // Reset sweep
    cyc("rst", 1'b1, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
    busy_cnt = 0;
    run_idle("rst_sweep");
    check("rst_sweep_len", 32'(busy_cnt), 32'd256);
    rd("rst_rd0", 9'd0);
    rd("rst_rd255", 9'd255);
    rd("rst_rd256", 9'd256);
    rd("rst_rd511", 9'd511);

    // Bank isolation
    cyc("wr5", 1'b0, 1'b0, 1'b1, 9'd5, 16'hBEEF, 1'b1);
    cyc("wr261", 1'b0, 1'b0, 1'b1, 9'd261, 16'h1234, 1'b1);
    rd("iso5", 9'd5);
    rd("iso261", 9'd261);
    rd("iso4", 9'd4);
    rd("iso260", 9'd260);
    check("iso_model5", 32'(m_mem[5]), 32'h0000BEEF);

    // Random reads and writes
    for (int i = 0; i < 300; i++)
      cyc("rand", 1'b0, 1'b0, 1'($urandom), 9'($urandom), 16'($urandom), 1'b1);

    // Fill, then clear request
    for (int a = 0; a < 512; a++)
      cyc("fill", 1'b0, 1'b0, 1'b1, 9'(a), 16'(a) ^ 16'hA5A5, 1'b1);
    for (int i = 0; i < 20; i++) rd("fill_rd", 9'($urandom));
    cyc("clr", 1'b0, 1'b1, 1'b0, 9'd3, 16'd0, 1'b1);
    busy_cnt = 0;
    run_idle("clr_sweep");
    check("clr_sweep_len", 32'(busy_cnt), 32'd256);
    for (int a = 0; a < 512; a++) rd("clr_rd", 9'(a));

    // Clear and load in the same idle cycle
    cyc("pre7", 1'b0, 1'b0, 1'b1, 9'd7, 16'h5555, 1'b1);
    rd("pre7_rd", 9'd7);
    cyc("clr_ld", 1'b0, 1'b1, 1'b1, 9'd7, 16'hFFFF, 1'b1);
    busy_cnt = 0;
    run_idle("clr_ld_sweep");
    check("clr_ld_len", 32'(busy_cnt), 32'd256);
    rd("clr_ld_rd7", 9'd7);

    // Writes blocked during sweep
    cyc("blk", 1'b0, 1'b1, 1'b0, 9'd0, 16'd0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) idle("blk_run");
    cyc("blk_wr100", 1'b0, 1'b0, 1'b1, 9'd100, 16'hFFFF, 1'b1);
    for (int i = 0; i < 239; i++) idle("blk_run");
    cyc("blk_wr356", 1'b0, 1'b0, 1'b1, 9'd356, 16'hFFFF, 1'b1);
    run_idle("blk_run");
    check("blk_len", 32'(busy_cnt), 32'd256);
    rd("blk_rd100", 9'd100);
    rd("blk_rd356", 9'd356);

    // Reset mid-sweep restarts the full sweep
    cyc("mrst", 1'b0, 1'b1, 1'b0, 9'd0, 16'd0, 1'b1);
    for (int i = 0; i < 199; i++) idle("mrst_run");
    cyc("mrst_rst", 1'b1, 1'b0, 1'b0, 9'd0, 16'd0, 1'b1);
    busy_cnt = 0;
    run_idle("mrst_run");
    check("mrst_len", 32'(busy_cnt), 32'd256);

    // Clear mid-sweep does not extend it
    cyc("mclr", 1'b0, 1'b1, 1'b0, 9'd0, 16'd0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 99; i++) idle("mclr_run");
    cyc("mclr_pulse", 1'b0, 1'b1, 1'b0, 9'd0, 16'd0, 1'b1);
    run_idle("mclr_run");
    check("mclr_len", 32'(busy_cnt), 32'd256);

    // Reset held high keeps the sweep pinned, counting starts on release
    cyc("hold", 1'b0, 1'b0, 1'b1, 9'd300, 16'h0BAD, 1'b1);
    for (int i = 0; i < 3; i++) cyc("hold_rst", 1'b1, 1'b0, 1'b0, 9'd300, 16'd0, i > 0);
    busy_cnt = 0;
    run_idle("hold_run");
    check("hold_len", 32'(busy_cnt), 32'd256);
    rd("hold_rd300", 9'd300);

    // Four-bank build
    @(negedge clk); q_reset = 1'b1;
    @(negedge clk); q_reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (q_busy !== 1'b1) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("q_sweep_len", 32'(busy_cnt), 32'd128);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      q_address = 9'(b * 128); q_in = 16'(16'h1100 * (b + 1)); q_load = 1'b1;
    end
    @(negedge clk); q_load = 1'b0;
    for (int b = 0; b < 4; b++) begin
      q_address = 9'(b * 128); #1;
      check("q_bank_rd", 32'(q_out), 32'(16'h1100 * (b + 1)));
      q_address = 9'(b * 128 + 1); #1;
      check("q_bank_nb", 32'(q_out), 32'd0);
    end

    // Single-bank corner build
    @(negedge clk); c_reset = 1'b1;
    @(negedge clk); c_reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      check("c_sweep_out", 32'(c_out), 32'd0);
      if (c_busy !== 1'b1) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("c_sweep_len", 32'(busy_cnt), 32'd16);
    @(negedge clk); c_address = 4'd15; c_in = 8'h7F; c_load = 1'b1;
    @(negedge clk); c_load = 1'b0; #1;
    check("c_rd15", 32'(c_out), 32'h7F);
    c_address = 4'd14; #1;
    check("c_rd14", 32'(c_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
